// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths and helpers for the decode-stage register file and its scoreboard.
// Flattened multi-port buses are indexed through portBase so every file slices them the same way.
package regfile_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int NUM_RD_DEF  = 2;
  localparam int NUM_WR_DEF  = 2;
  localparam int CNT_W_DEF   = 2;
  localparam int ZERO_R0_DEF = 1;

  // Bit offset of port 'port' inside a flattened bus of 'width'-bit fields.
  function automatic int portBase(int port, int width);
    return port * width;
  endfunction

  // Register 0 is hardwired to zero and never tracked when zeroR0 is set.
  function automatic logic isScoreboarded(int zeroR0, int addr);
    return !((zeroR0 != 0) && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard_counters.sv
// Per-register pending-write counters with one increment (issue) and several
// decrements (writeback releases plus a squashed ID/EX entry), and the RAW/WAW hazard query.
module scoreboard_counters
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int NUM_WR  = NUM_WR_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ZERO_R0 = ZERO_R0_DEF
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iIncEn,
  input  logic [ADDR_W-1:0]        iIncAddr,
  input  logic [NUM_WR-1:0]        iWbRelease,
  input  logic [NUM_WR*ADDR_W-1:0] iWbAddr,
  input  logic                     iFlushDec,
  input  logic [ADDR_W-1:0]        iFlushAddr,
  input  logic [NUM_RD*ADDR_W-1:0] iSrcAddr,
  input  logic [NUM_RD-1:0]        iSrcEn,
  input  logic                     iDstEn,
  input  logic [ADDR_W-1:0]        iDstAddr,
  output logic                     oHazard
);

  localparam int NREG = 2 ** ADDR_W;

  logic [CNT_W-1:0] pend     [NREG];
  logic [CNT_W-1:0] pendNext [NREG];
  logic [NREG-1:0]  releaseHit;
  logic [NREG-1:0]  underflow;

  // Net change per register; a release on an idle counter clamps at zero.
  always_comb begin
    int sum;
    sum        = 0;
    releaseHit = '0;
    underflow  = '0;
    for (int r = 0; r < NREG; r++) begin
      pendNext[r] = pend[r];
      sum = int'(pend[r]);
      if (iIncEn && (iIncAddr == ADDR_W'(r))) sum = sum + 1;
      for (int w = 0; w < NUM_WR; w++) begin
        if (iWbRelease[w] && (iWbAddr[portBase(w, ADDR_W) +: ADDR_W] == ADDR_W'(r))) begin
          releaseHit[r] = 1'b1;
          sum = sum - 1;
        end
      end
      if (iFlushDec && (iFlushAddr == ADDR_W'(r))) sum = sum - 1;
      if (!isScoreboarded(ZERO_R0, r)) begin
        sum           = 0;
        releaseHit[r] = 1'b0;
      end
      if (sum < 0) begin
        underflow[r] = 1'b1;
        sum          = 0;
      end
      pendNext[r] = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) pend[r] <= pendNext[r];
    end
  end

  // A single pending write may be consumed in the same cycle its release arrives.
  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    oHazard = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = iSrcAddr[portBase(k, ADDR_W) +: ADDR_W];
      if (iSrcEn[k]) begin
        if (pend[a] > CNT_W'(1)) oHazard = 1'b1;
        else if ((pend[a] == CNT_W'(1)) && !releaseHit[a]) oHazard = 1'b1;
      end
    end
    if (iDstEn && (pend[iDstAddr] == '1)) oHazard = 1'b1;
  end

  underflowFree: assert property (@(posedge iClk) disable iff (!iRst_n) underflow == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: storage array, writeback bypass into the operand read,
// issue handshake against the scoreboard and the registered ID/EX operand stage.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int NUM_WR  = NUM_WR_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ZERO_R0 = ZERO_R0_DEF
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iIssueValid,
  output logic                     oIssueReady,
  input  logic [NUM_RD*ADDR_W-1:0] iSrcAddr,
  input  logic [NUM_RD-1:0]        iSrcEn,
  input  logic [ADDR_W-1:0]        iDstAddr,
  input  logic                     iDstEn,
  output logic                     oOutValid,
  output logic [NUM_RD*DATA_W-1:0] oSrcData,
  output logic [ADDR_W-1:0]        oDstAddr,
  output logic                     oDstEn,
  input  logic                     iStall,
  input  logic                     iFlush,
  input  logic [NUM_WR-1:0]        iWbRelease,
  input  logic [NUM_WR-1:0]        iWbEn,
  input  logic [NUM_WR*ADDR_W-1:0] iWbAddr,
  input  logic [NUM_WR*DATA_W-1:0] iWbData
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0]        regs [NREG];
  logic [NUM_RD*DATA_W-1:0] srcRead;
  logic                     hazard;
  logic                     fire;
  logic                     incEn;
  logic                     flushDec;

  assign oIssueReady = !hazard && !iFlush && (!oOutValid || !iStall);
  assign fire        = iIssueValid && oIssueReady;
  assign incEn       = fire && iDstEn && isScoreboarded(ZERO_R0, int'(iDstAddr));
  // A squashed ID/EX instruction will never write back, so its pending count is returned here.
  assign flushDec    = iFlush && oOutValid && oDstEn && isScoreboarded(ZERO_R0, int'(oDstAddr));

  scoreboard_counters #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .CNT_W  (CNT_W),
    .ZERO_R0(ZERO_R0)
  ) uCounters (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iIncEn    (incEn),
    .iIncAddr  (iDstAddr),
    .iWbRelease(iWbRelease),
    .iWbAddr   (iWbAddr),
    .iFlushDec (flushDec),
    .iFlushAddr(oDstAddr),
    .iSrcAddr  (iSrcAddr),
    .iSrcEn    (iSrcEn),
    .iDstEn    (iDstEn),
    .iDstAddr  (iDstAddr),
    .oHazard   (hazard)
  );

  // Same-cycle writeback data overrides the array; the highest port index wins.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    a       = '0;
    v       = '0;
    srcRead = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = iSrcAddr[portBase(k, ADDR_W) +: ADDR_W];
      v = regs[a];
      for (int w = 0; w < NUM_WR; w++) begin
        if (iWbRelease[w] && iWbEn[w] && (iWbAddr[portBase(w, ADDR_W) +: ADDR_W] == a))
          v = iWbData[portBase(w, DATA_W) +: DATA_W];
      end
      if (!isScoreboarded(ZERO_R0, int'(a))) v = '0;
      if (!iSrcEn[k]) v = '0;
      srcRead[portBase(k, DATA_W) +: DATA_W] = v;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (iWbRelease[w] && iWbEn[w] &&
            isScoreboarded(ZERO_R0, int'(iWbAddr[portBase(w, ADDR_W) +: ADDR_W])))
          regs[iWbAddr[portBase(w, ADDR_W) +: ADDR_W]] <= iWbData[portBase(w, DATA_W) +: DATA_W];
      end
    end
  end

  // Flush beats stall; an unaccepted slot drains once EX is free.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oOutValid <= 1'b0;
      oSrcData  <= '0;
      oDstAddr  <= '0;
      oDstEn    <= 1'b0;
    end else if (iFlush) begin
      oOutValid <= 1'b0;
    end else if (fire) begin
      oOutValid <= 1'b1;
      oSrcData  <= srcRead;
      oDstAddr  <= iDstAddr;
      oDstEn    <= iDstEn;
    end else if (!iStall) begin
      oOutValid <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised register file for the decode stage, with a scoreboard of in-flight destination writes, same-cycle writeback bypass and a registered ID/EX operand output.
- Replaces the fixed 2-read/1-write file and ad-hoc latching of the previous decode stage.
- Accepts decoded source and destination fields from Control and stalls issue on RAW hazards.
- Takes NUM_WR writeback ports, so multiple units (ALU, MDU, FPU, memory) can retire per cycle.

Parameters:
DATA_W, 32, register width
ADDR_W, 5, register address width; NREG = 2**ADDR_W
NUM_RD, 2, read (source) ports
NUM_WR, 2, writeback ports
CNT_W, 2, per-register pending-write counter width
ZERO_R0, 1, 1 = register 0 reads 0, is never written and is never scoreboarded

Ports:
iClk  in  1  clock
iRst_n  in  1  synchronous active-low reset
iIssueValid  in  1  decoded instruction present
oIssueReady  out  1  instruction accepted this cycle when high together with iIssueValid (fire)
iSrcAddr  in  NUM_RD*ADDR_W  source addresses, port k at [k*ADDR_W +: ADDR_W]
iSrcEn  in  NUM_RD  source read enables
iDstAddr  in  ADDR_W  destination address
iDstEn  in  1  instruction writes iDstAddr
oOutValid  out  1  ID/EX operand register holds a valid instruction
oSrcData  out  NUM_RD*DATA_W  registered operands
oDstAddr  out  ADDR_W  registered destination
oDstEn  out  1  registered destination enable
iStall  in  1  EX not accepting; hold the ID/EX register
iFlush  in  1  squash the ID/EX register and block issue this cycle
iWbRelease  in  NUM_WR  retire one pending write at iWbAddr
iWbEn  in  NUM_WR  also write data; ignored unless iWbRelease is set
iWbAddr  in  NUM_WR*ADDR_W  writeback addresses
iWbData  in  NUM_WR*DATA_W  writeback data

Behaviour:
- Reset: all registers 0, all counters 0, oOutValid 0, oSrcData 0, oDstAddr 0, oDstEn 0.
- Scoreboard: pend[r] is a CNT_W-bit counter per register.
- Next value: pend[r] + inc − dec.
  - inc = 1 on fire with iDstEn and scoreboarded(iDstAddr).
  - dec = count of ports w with iWbRelease[w] and iWbAddr[w] == r, plus 1 if the flush release below applies.
- scoreboarded(a) = !(ZERO_R0 && a == 0).
- A release on a counter already at 0 is a protocol error: the counter holds at 0 (simulation assertion).
- Hazard, per enabled source k with address a:
  - pend[a] > 1 → hazard.
  - pend[a] == 1 and no release to a this cycle → hazard.
  - pend[a] == 1 and a release to a this cycle → no hazard.
- WAW limit: iDstEn and pend[iDstAddr] == all-ones → hazard; issue blocks rather than saturating.
- oIssueReady = !hazard && !iFlush && (!oOutValid || !iStall). The value is independent of iIssueValid.
- Operand read, combinational: source value on fire is
  - the highest-index w with iWbRelease[w] && iWbEn[w] && iWbAddr[w] == a, if any (bypass);
  - else array[a];
  - 0 if ZERO_R0 && a == 0;
  - 0 if iSrcEn[k] == 0.
- Array write: at the clock edge for each w with release and enable, unless address 0 with ZERO_R0. On the same address, the higher w wins.
- ID/EX register, 1-cycle latency:
  - Fire → oOutValid 1 and capture operands, dst and dstEn next cycle.
  - Else if !iStall → oOutValid 0.
  - Else hold.
- Flush:
  - oOutValid <= 0.
  - If oOutValid && oDstEn && scoreboarded(oDstAddr), decrement pend[oDstAddr] internally, because the squashed instruction never reaches writeback.
  - Flush has priority over iStall.
  - Instructions already past EX are not flushed here. They must present iWbRelease with iWbEn = 0.
- Simultaneous issue and release to the same register: net change = inc − dec. The bypass rule guarantees a consumer never reads stale data.
- Reset mid-operation clears all state immediately. Pending writebacks after reset are protocol errors and clamp at 0.

Decomposition:
- Shared package `regfile_pkg`: default widths, NREG, the ZERO_R0 convention, and a function to extract port slices from flattened buses.
- One sub-module, `scoreboard_counters`: the NREG counters with inc/multi-dec and the hazard query.
- The top level holds the storage array, bypass muxes and the ID/EX register.

Test Plan:
- Reset, then issue r3 ← (r1, r2) with all zero → oSrcData = {0, 0} one cycle later and pend[3] == 1; a later issue reading r3 stalls (oIssueReady = 0) until a release to r3.
- Release w0 r3 = 0xDEADBEEF in the same cycle as an issue reading r3 → fire; next cycle oSrcData[0] = 0xDEADBEEF and pend[3] == 0.
- Two writes to r5 in flight (pend = 2) with a release of one → reader still stalls; second release with data 0x5 → reader fires and gets 0x5.
- Both WB ports write r7 the same cycle (0x11 on w0, 0x22 on w1) with pend = 2 → array r7 = 0x22 and pend = 0.
- iFlush while oOutValid = 1 with dst r9 and pend[9] = 1 → oOutValid = 0, pend[9] = 0, oIssueReady = 0 that cycle.
- iStall held 3 cycles with oOutValid = 1 → outputs stable and oIssueReady = 0; write to r0 with 0xFFFF → r0 still reads 0.
